// File: rtl/spi_pkg.sv
// Shared encodings for the SPI register bank: command ops, FSM states and the
// special CLR_ERR address, plus small decode helpers.
package spi_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMD  = 2'b01,
        DATA = 2'b10
    } state_e;

    localparam logic [5:0] CLR_ERR_ADDR = 6'h3F;

    function automatic logic is_clr_err(input op_e op, input logic [5:0] addr);
        return (op == OP_READ) && (addr == CLR_ERR_ADDR);
    endfunction

    function automatic logic [7:0] apply_op(input op_e op, input logic [7:0] cur,
                                            input logic [7:0] data);
        logic [7:0] res;
        case (op)
            OP_WRITE: res = data;
            OP_SET:   res = cur | data;
            OP_CLR:   res = cur & ~data;
            default:  res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// SPI mode-0 front end: input synchronisers, edge detection, byte assembly
// and the MSB-first transmit shifter, all in the clk domain.
module spi_byte_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       ss_fall,
    output logic       ss_rise,
    output logic       ss_active,
    output logic       tx_bit
);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] valid_r;
    logic                   sclk_prev_r;
    logic                   ss_prev_r;
    logic                   armed_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             rx_sh_r;
    logic [7:0]             rx_byte_r;
    logic                   byte_done_r;
    logic [7:0]             tx_sh_r;

    logic sclk_s, ss_s, mosi_s, rise_s, fall_s, active_s;

    assign sclk_s   = clk_sync_r[SYNC_STAGES-1];
    assign ss_s     = ss_sync_r[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_r[SYNC_STAGES-1];
    assign rise_s   = sclk_s & ~sclk_prev_r;
    assign fall_s   = ~sclk_s & sclk_prev_r;
    // armed_r ignores a transaction already in flight when reset was released
    assign active_s = armed_r & ~ss_s;

    assign ss_fall   = armed_r & ss_prev_r & ~ss_s;
    assign ss_rise   = armed_r & ~ss_prev_r & ss_s;
    assign ss_active = active_s;
    assign byte_done = byte_done_r;
    assign rx_byte   = rx_byte_r;
    assign tx_bit    = tx_sh_r[7];

    // Synchronisers (idle level during reset) and edge-history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r  <= {SYNC_STAGES{1'b0}};
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            valid_r     <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
            ss_prev_r   <= 1'b1;
            armed_r     <= 1'b0;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], spi_clk};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], spi_ss};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            valid_r     <= {valid_r[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_r <= sclk_s;
            ss_prev_r   <= ss_s;
            armed_r     <= armed_r | (valid_r[SYNC_STAGES-1] & ss_s);
        end
    end

    // Receive shifter, bit counter, byte_done pulse and transmit shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r   <= 3'd0;
            rx_sh_r     <= 8'h00;
            rx_byte_r   <= 8'h00;
            byte_done_r <= 1'b0;
            tx_sh_r     <= 8'h00;
        end else begin
            byte_done_r <= 1'b0;
            if (!active_s) begin
                bit_cnt_r <= 3'd0;
            end else if (rise_s) begin
                rx_sh_r   <= {rx_sh_r[6:0], mosi_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_done_r <= 1'b1;
                    rx_byte_r   <= {rx_sh_r[6:0], mosi_s};
                end
            end
            // the falling edge right after a byte boundary must keep the fresh MSB
            if (tx_load) begin
                tx_sh_r <= tx_data;
            end else if (active_s && fall_s && (bit_cnt_r != 3'd0)) begin
                tx_sh_r <= {tx_sh_r[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-accessible bank of 8-bit registers: command decode, WRITE/SET/CLR/READ
// with auto-increment, sticky range error and write strobe.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int         NUM_REGS    = 4,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_clk,
    input  logic                  spi_ss,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  wr_strobe,
    output logic [5:0]            wr_addr,
    output logic                  err_sticky
);

    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);
    localparam logic [5:0] LAST_ADDR  = 6'(NUM_REGS - 1);

    function automatic logic in_range(input op_e op, input logic [5:0] addr);
        return ({1'b0, addr} < NUM_REGS_W) && !is_clr_err(op, addr);
    endfunction

    state_e     state_r, next_state_s;
    op_e        op_r;
    logic [5:0] addr_r;
    logic       err_r;
    logic       wr_strobe_r;
    logic [5:0] wr_addr_r;
    logic       miso_r;
    logic [7:0] regs_r [NUM_REGS];

    logic       byte_done_s, ss_fall_s, ss_rise_s, ss_active_s, tx_bit_s;
    logic [7:0] rx_byte_s;
    op_e        cmd_op_s, look_op_s;
    logic [5:0] cmd_addr_s, addr_next_s, look_addr_s;
    logic       cur_ok_s;
    logic [7:0] tx_data_s, new_val_s;

    spi_byte_engine #(.SYNC_STAGES(SYNC_STAGES)) u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .tx_load   (byte_done_s),
        .tx_data   (tx_data_s),
        .byte_done (byte_done_s),
        .rx_byte   (rx_byte_s),
        .ss_fall   (ss_fall_s),
        .ss_rise   (ss_rise_s),
        .ss_active (ss_active_s),
        .tx_bit    (tx_bit_s)
    );

    assign cmd_op_s    = op_e'(rx_byte_s[7:6]);
    assign cmd_addr_s  = rx_byte_s[5:0];
    assign cur_ok_s    = in_range(op_r, addr_r);
    assign addr_next_s = (addr_r == LAST_ADDR) ? 6'd0 : addr_r + 6'd1;
    assign new_val_s   = apply_op(op_r, regs_r[addr_r[AW-1:0]], rx_byte_s);

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ss_fall_s) next_state_s = CMD;
                else           next_state_s = IDLE;
            end
            CMD: begin
                if (ss_rise_s)        next_state_s = IDLE;
                else if (byte_done_s) next_state_s = DATA;
                else                  next_state_s = CMD;
            end
            DATA: begin
                if (ss_rise_s) next_state_s = IDLE;
                else           next_state_s = DATA;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Read data for the byte that follows the one just completed
    always_comb begin
        look_op_s   = op_r;
        look_addr_s = addr_r;
        tx_data_s   = 8'h00;
        if (state_r == CMD) begin
            look_op_s   = cmd_op_s;
            look_addr_s = cmd_addr_s;
        end else if (cur_ok_s) begin
            look_addr_s = addr_next_s;
        end else begin
            look_addr_s = addr_r;
        end
        if ((look_op_s == OP_READ) && in_range(look_op_s, look_addr_s)) begin
            tx_data_s = regs_r[look_addr_s[AW-1:0]];
        end else begin
            tx_data_s = 8'h00;
        end
    end

    // FSM state, decode registers, register file, strobe, error flag and MISO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= OP_WRITE;
            addr_r      <= 6'd0;
            err_r       <= 1'b0;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 6'd0;
            miso_r      <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_r[k] <= RESET_VAL;
        end else begin
            state_r     <= next_state_s;
            wr_strobe_r <= 1'b0;
            miso_r      <= (state_r == DATA) && ss_active_s && tx_bit_s;
            if (byte_done_s && (state_r == CMD)) begin
                op_r   <= cmd_op_s;
                addr_r <= cmd_addr_s;
                if (is_clr_err(cmd_op_s, cmd_addr_s)) begin
                    err_r <= 1'b0;
                end else if (!in_range(cmd_op_s, cmd_addr_s)) begin
                    err_r <= 1'b1;
                end
            end else if (byte_done_s && (state_r == DATA) && cur_ok_s) begin
                addr_r <= addr_next_s;
                if (op_r != OP_READ) begin
                    regs_r[addr_r[AW-1:0]] <= new_val_s;
                    wr_strobe_r            <= 1'b1;
                    wr_addr_r              <= addr_r;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign regs_out[8*k +: 8] = regs_r[k];
    end

    assign spi_miso   = miso_r;
    assign wr_strobe  = wr_strobe_r;
    assign wr_addr    = wr_addr_r;
    assign err_sticky = err_r;

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of 8-bit registers; legal range 1..64.
REQ-002 SHALL have parameter RESET_VAL, default 8'h00, reset value of every register.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for SPI inputs; minimum 2.
REQ-004 SHALL have port clk  input  1  system clock; the only clock; all state on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports spi_clk, spi_ss, spi_mosi  input  1 each  SPI mode 0; spi_ss is active-low.
REQ-007 SHALL have port spi_miso  output  1  serial read data, MSB first.
REQ-008 SHALL have port regs_out  output  8*NUM_REGS  all registers, reg k on bits [8k+7:8k].
REQ-009 SHALL have port wr_strobe  output  1  one-cycle pulse on any register update.
REQ-010 SHALL have port wr_addr  output  6  address of the update flagged by wr_strobe.
REQ-011 SHALL have port err_sticky  output  1  set on out-of-range access; cleared only by reset or by the CLR_ERR command.

Function
REQ-012 SHALL synchronise spi_clk, spi_ss and spi_mosi through SYNC_STAGES flops; clk SHALL be at least 4x spi_clk.
REQ-013 SHALL sample spi_mosi on detected spi_clk rising edges and update spi_miso on detected falling edges, MSB first.
REQ-014 SHALL complete a byte on the 8th sampled bit; byte_done pulses for exactly one clk cycle.
REQ-015 SHALL use FSM states IDLE, CMD, DATA: IDLE->CMD on spi_ss falling; CMD->DATA on byte_done; any state->IDLE on spi_ss rising.
REQ-016 SHALL discard a partial byte when spi_ss rises mid-byte, with no register change and no strobe.
REQ-017 SHALL decode the command byte as op = cmd[7:6], addr = cmd[5:0].
REQ-018 Op 00 WRITE: each DATA byte SHALL replace reg[addr].
REQ-019 Op 01 SET: each DATA byte SHALL be ORed into reg[addr].
REQ-020 Op 10 CLR: each DATA byte SHALL clear the set bits of reg[addr] (AND NOT).
REQ-021 Op 11 READ: SHALL shift reg[addr] out on spi_miso during the next byte; addr 6'h3F with op 11 SHALL be CLR_ERR and return 8'h00.
REQ-022 SHALL auto-increment addr after each DATA byte, wrapping from NUM_REGS-1 to 0.
REQ-023 SHALL update a register on the clk edge after byte_done, and assert wr_strobe with wr_addr in that same cycle.
REQ-024 An access with addr >= NUM_REGS (except CLR_ERR) SHALL set err_sticky, ignore the write and return 8'h00; auto-increment SHALL not apply.
REQ-025 SHALL load the READ shift register on byte_done of the preceding byte, so the first bit is valid before the first rising spi_clk.
REQ-026 SHALL drive spi_miso as 0 while spi_ss is high and while in the CMD state.
REQ-027 A write and a read of the same register in one byte SHALL return the pre-write value.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set all registers to RESET_VAL, the FSM to IDLE, the bit counter to 0, and spi_miso, wr_strobe, wr_addr and err_sticky to 0.
REQ-029 SHALL hold all synchroniser flops at their idle level (spi_ss=1, spi_clk=0) during reset.
REQ-030 After rst_n rises mid-transaction, SHALL ignore traffic until spi_ss is seen high.

Structure
REQ-031 SHALL place op encodings, FSM state encodings and the CLR_ERR address in the shared package spi_pkg.
REQ-032 SHALL use a single sub-module, spi_byte_engine, for synchronisation, edge detection, shifting and byte_done; decode and register storage stay in spi_reg_bank.

Verification
REQ-033 Reset, then read all registers -> each returns 8'h00 and err_sticky = 0.
REQ-034 Send CMD 8'h02 then data 8'hA5 -> reg2 = 8'hA5, with one wr_strobe and wr_addr = 2.
REQ-035 Send WRITE 8'h03 then 8'h11, 8'h22 (NUM_REGS=4) -> reg3 = 8'h11, reg0 = 8'h22 (wrap).
REQ-036 Set reg1 = 8'hF0, then SET 8'h0F, then CLR 8'h81 -> reg1 reads 8'h7E.
REQ-037 Send WRITE to addr 5 (NUM_REGS=4) -> no register change and err_sticky = 1; then CMD 8'hFF -> err_sticky = 0.
REQ-038 Raise spi_ss after 4 bits of a data byte -> no strobe, and the next transaction decodes correctly.
